instruction_loader: RTL and testbench

//  Writer side of the program memory read by the fetch stage. Receives program bytes from the

---
 rtl/instruction_loader_pkg.sv | 15 +
 rtl/instruction_loader_byte_assembler.sv | 40 ++++
 rtl/instruction_loader.sv | 108 ++++++++++
 tb/tb_instruction_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared constants and state encoding for the program loader
package instruction_loader_pkg;

  localparam logic [31:0] HALT_WORD      = 32'hFFFF_FFFF;
  localparam int          BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } load_state_e;

endpackage

// File: rtl/instruction_loader_byte_assembler.sv
// rtl/instruction_loader_byte_assembler.sv - packs UART bytes big-endian into instruction words
module instruction_loader_byte_assembler
  import instruction_loader_pkg::*;
#(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_shift,
  input  logic               i_clear,
  input  logic [NB_BYTE-1:0] i_byte,
  output logic [NB_DATA-1:0] o_word,
  output logic               o_word_ready
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  // Only the first three bytes need storing; the fourth is taken straight from the input.
  logic [NB_DATA-NB_BYTE-1:0] shift_q;
  logic [1:0]                 count_q;

  assign o_word       = {shift_q, i_byte};
  assign o_word_ready = i_shift && !i_clear && (count_q == LAST_BYTE);

  // Byte counter and shift register; clear wins over shift so a discarded byte never lands.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (i_clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (i_shift) begin
      shift_q <= o_word[NB_DATA-NB_BYTE-1:0];
      count_q <= count_q + 2'd1;
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - writes UART-received program words into program memory
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDRESS = 6,
  parameter int NB_BYTE    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_wr_en,
  output logic [NB_ADDRESS-1:0] o_wr_addr,
  output logic [NB_DATA-1:0]    o_wr_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_overflow
);

  localparam logic [NB_ADDRESS-1:0] ADDR_STEP = NB_ADDRESS'(BYTES_PER_WORD);
  localparam logic [NB_ADDRESS-1:0] LAST_ADDR = {{(NB_ADDRESS-2){1'b1}}, 2'b00};

  load_state_e           state_q, state_d;
  logic [NB_ADDRESS-1:0] addr_q, addr_d;        // address the next completed word goes to
  logic [NB_ADDRESS-1:0] wr_addr_q, wr_addr_d;  // last written address, held for the port
  logic [NB_DATA-1:0]    wr_data_q, wr_data_d;  // last written word, held for the port
  logic                  asm_shift, asm_clear, asm_ready;
  logic [NB_DATA-1:0]    asm_word;

  instruction_loader_byte_assembler #(
    .NB_DATA (NB_DATA),
    .NB_BYTE (NB_BYTE)
  ) u_byte_assembler (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_shift      (asm_shift),
    .i_clear      (asm_clear),
    .i_byte       (i_rx_data),
    .o_word       (asm_word),
    .o_word_ready (asm_ready)
  );

  assign o_wr_en    = (state_q == ST_WRITE);
  assign o_busy     = (state_q == ST_RECV) || (state_q == ST_WRITE);
  assign o_done     = (state_q == ST_DONE);
  assign o_overflow = (state_q == ST_ERROR);
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;

  // State, address and held write-port registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state logic; bytes are accepted in WRITE too so back-to-back UART bytes are not lost.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    asm_shift = 1'b0;
    asm_clear = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          state_d   = ST_RECV;
          addr_d    = '0;
          asm_clear = 1'b1;
        end
      end
      ST_RECV: begin
        asm_shift = i_rx_valid;
        if (asm_ready) begin
          state_d   = ST_WRITE;
          wr_addr_d = addr_q;
          wr_data_d = asm_word;
        end
      end
      ST_WRITE: begin
        if (wr_data_q == HALT_WORD) begin
          state_d   = ST_DONE;
          asm_clear = 1'b1;
        end else if (wr_addr_q == LAST_ADDR) begin
          state_d   = ST_ERROR;
          asm_clear = 1'b1;
        end else begin
          state_d   = ST_RECV;
          addr_d    = addr_q + ADDR_STEP;
          asm_shift = i_rx_valid;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed self-checking bench for instruction_loader
module tb_instruction_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic        overflow;

  int vectors;
  int errors;

  logic [5:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  instruction_loader dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_start    (start),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_busy     (busy),
    .o_done     (done),
    .o_overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(v[31:24]);
      v = v << 8;
    end
  endtask

  task automatic check_write(input int idx, input logic [5:0] ea, input logic [31:0] ed);
    vectors++;
    if (idx >= wq_addr.size()) begin
      errors++;
      $display("FAIL write[%0d]: missing, got %0d strobes, required addr %h data %h",
               idx, wq_addr.size(), ea, ed);
    end else if (wq_addr[idx] !== ea || wq_data[idx] !== ed) begin
      errors++;
      $display("FAIL write[%0d]: got addr %h data %h, required addr %h data %h",
               idx, wq_addr[idx], wq_data[idx], ea, ed);
    end
  endtask

  task automatic check_flags(input string name, input logic eb, input logic ed, input logic eo);
    vectors++;
    if (busy !== eb || done !== ed || overflow !== eo) begin
      errors++;
      $display("FAIL %s flags: got busy=%b done=%b ovf=%b, required busy=%b done=%b ovf=%b",
               name, busy, done, overflow, eb, ed, eo);
    end
  endtask

  task automatic check_count(input string name, input int expected);
    vectors++;
    if (wq_addr.size() != expected) begin
      errors++;
      $display("FAIL %s strobes: got %0d, required %0d", name, wq_addr.size(), expected);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if (wr_en !== 1'b0 || wr_addr !== 6'h00 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL reset port: got en=%b addr=%h data=%h, required 0/00/00000000",
               wr_en, wr_addr, wr_data);
    end
    check_flags("reset", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    check_flags("basic_recv", 1'b1, 1'b0, 1'b0);
    send_word(32'h2008_0005);
    send_word(32'hFFFF_FFFF);
    tick();
    check_count("basic", 2);
    check_write(0, 6'h00, 32'h2008_0005);
    check_write(1, 6'h04, 32'hFFFF_FFFF);
    check_flags("basic_done", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    for (int i = 1; i <= 8; i++) begin
      rx_data  = 8'(i);
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    tick();
    tick();
    check_count("b2b", 2);
    check_write(0, 6'h00, 32'h0102_0304);
    check_write(1, 6'h04, 32'h0506_0708);
    check_flags("b2b_recv", 1'b1, 1'b0, 1'b0);
    send_word(32'hFFFF_FFFF);
    tick();
    check_write(2, 6'h08, 32'hFFFF_FFFF);
    check_flags("b2b_done", 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    for (int w = 0; w < 16; w++) send_word(32'h1000_0000 + 32'(w));
    tick();
    check_count("ovf", 16);
    for (int w = 0; w < 16; w++) check_write(w, 6'(w * 4), 32'h1000_0000 + 32'(w));
    check_flags("ovf_error", 1'b0, 1'b0, 1'b1);
    send_word(32'hFFFF_FFFF);
    tick();
    check_count("ovf_no17", 16);
    check_flags("ovf_hold", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midload();
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    send_word(32'h1111_2222);
    send_byte(8'h33);
    send_byte(8'h44);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (wr_en !== 1'b0 || wr_addr !== 6'h00 || wr_data !== 32'h0) begin
      errors++;
      $display("FAIL midreset port: got en=%b addr=%h data=%h, required 0/00/00000000",
               wr_en, wr_addr, wr_data);
    end
    check_flags("midreset", 1'b0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
    send_word(32'hAABB_CCDD);
    send_word(32'hFFFF_FFFF);
    tick();
    check_count("restart", 2);
    check_write(0, 6'h00, 32'hAABB_CCDD);
    check_write(1, 6'h04, 32'hFFFF_FFFF);
  endtask

  task automatic test_ignored_inputs();
    wq_addr.delete();
    wq_data.delete();
    for (int i = 0; i < 5; i++) send_byte(8'h5A);
    check_count("done_rx", 0);
    check_flags("done_rx", 1'b0, 1'b1, 1'b0);
    vectors++;
    if (wr_addr !== 6'h04 || wr_data !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL done_hold: got addr %h data %h, required 04 ffffffff", wr_addr, wr_data);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) send_byte(8'hA5);
    check_count("idle_rx", 0);
    check_flags("idle_rx", 1'b0, 1'b0, 1'b0);
    pulse_start();
    send_byte(8'hDE);
    send_byte(8'hAD);
    pulse_start();
    send_byte(8'hBE);
    send_byte(8'hEF);
    tick();
    check_count("start_in_recv", 1);
    check_write(0, 6'h00, 32'hDEAD_BEEF);
    send_word(32'hFFFF_FFFF);
    tick();
    check_write(1, 6'h04, 32'hFFFF_FFFF);
  endtask

  task automatic test_restart_after_done();
    wq_addr.delete();
    wq_data.delete();
    check_flags("pre_restart", 1'b0, 1'b1, 1'b0);
    pulse_start();
    check_flags("restart_edge", 1'b1, 1'b0, 1'b0);
    send_word(32'h1234_5678);
    send_word(32'hFFFF_FFFF);
    tick();
    check_count("restart_done", 2);
    check_write(0, 6'h00, 32'h1234_5678);
    check_write(1, 6'h04, 32'hFFFF_FFFF);
    check_flags("restart_done", 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    vectors  = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    test_reset();
    test_basic_load();
    test_back_to_back();
    test_overflow();
    test_reset_midload();
    test_ignored_inputs();
    test_restart_after_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
